// File: rtl/ring_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ring_buffer_ctrl
// Purpose  : Single-clock ring buffer with transactional reads. Reads made
//            between open and commit are tentative. A rollback rewinds the
//            read pointer to the point captured at open. Space freed by
//            tentative reads is not reusable until commit.
//
// Ports    : clk        in   clock, rising edge
//            rst        in   synchronous, active-high reset
//            push_data  in   [DATA_W-1:0] word to store
//            push_req   in   single-cycle write request
//            push_done  out  one-cycle ack, word stored
//            pop_req    in   single-cycle read request
//            pop_data   out  [DATA_W-1:0] read word, valid with pop_done
//            pop_done   out  one-cycle ack, pop_data valid
//            open       in   start a read transaction (pulse)
//            commit     in   accept reads since open (pulse)
//            rollback   in   discard reads since open (pulse)
//            mem_used   out  [ADDR_W:0] words available to pop
//
// Optional : RING_BUFFER_STATUS_EN adds the following ports:
//            status_clr in   clears the sticky flags
//            overflow   out  sticky, set when a push is dropped
//            underflow  out  sticky, set when a pop finds nothing to read
//
// Revision : 1.0  initial release
// ============================================================================
module ring_buffer_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_req,
  output logic              push_done,
  input  logic              pop_req,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_done,
  input  logic              open,
  input  logic              commit,
  input  logic              rollback,
`ifdef RING_BUFFER_STATUS_EN
  input  logic              status_clr,
  output logic              overflow,
  output logic              underflow,
`endif
  output logic [ADDR_W:0]   mem_used
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  // A pointer difference equal to this means every slot is committed.
  localparam logic [PTR_W-1:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRANS = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_rd_base;
  logic [PTR_W-1:0] w_wr_ptr_next;
  logic [PTR_W-1:0] w_rd_ptr_next;
  logic [PTR_W-1:0] w_rd_base_next;

  logic             w_full;
  logic             w_avail;
  logic             w_push_ok;
  logic             w_pop_ok;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Fullness is judged against rd_base rather than rd_ptr, so slots read
  // inside an open transaction stay reserved until the commit.
  assign w_full    = ((r_wr_ptr - r_rd_base) == DEPTH_CNT);
  assign w_avail   = (mem_used != '0);
  assign w_push_ok = push_req && !w_full;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and pointer update logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_pop_ok       = 1'b0;
    w_wr_ptr_next  = r_wr_ptr;
    w_rd_ptr_next  = r_rd_ptr;
    w_rd_base_next = r_rd_base;

    if (w_push_ok) begin
      w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
    end

    case (r_state)
      ST_IDLE: begin
        w_pop_ok = pop_req && w_avail;
        if (w_pop_ok) begin
          w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
        end
        if (open) begin
          // The transaction starts before any pop issued in this same cycle,
          // so such a pop becomes part of the transaction.
          w_state_next   = ST_TRANS;
          w_rd_base_next = r_rd_ptr;
        end else begin
          // Outside a transaction, reads are final immediately. Tracking the
          // post-pop pointer frees the slot for writing on the next cycle.
          w_rd_base_next = w_rd_ptr_next;
        end
      end

      ST_TRANS: begin
        if (rollback) begin
          // Rollback wins over commit. Any pop in this cycle is dropped
          // because the read pointer is being rewound.
          w_state_next   = ST_IDLE;
          w_rd_ptr_next  = r_rd_base;
          w_rd_base_next = r_rd_base;
        end else begin
          w_pop_ok = pop_req && w_avail;
          if (w_pop_ok) begin
            w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
          end
          if (commit) begin
            w_state_next   = ST_IDLE;
            w_rd_base_next = w_rd_ptr_next;
          end
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Pointers, acknowledges and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_rd_base <= '0;
      push_done <= 1'b0;
      pop_done  <= 1'b0;
      mem_used  <= '0;
    end else begin
      r_wr_ptr  <= w_wr_ptr_next;
      r_rd_ptr  <= w_rd_ptr_next;
      r_rd_base <= w_rd_base_next;
      push_done <= w_push_ok;
      pop_done  <= w_pop_ok;
      mem_used  <= w_wr_ptr_next - w_rd_ptr_next;
    end
  end

  // --------------------------------------------------------------------------
  // Storage: the write port has no reset so the array maps onto RAM.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= push_data;
    end
  end

  // The read register is reset so that pop_data powers up at zero. Between
  // pops it holds the last word read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pop_data <= '0;
    end else if (w_pop_ok) begin
      pop_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
    end
  end

`ifdef RING_BUFFER_STATUS_EN
  // --------------------------------------------------------------------------
  // Sticky status flags. A new event takes priority over a clear.
  // --------------------------------------------------------------------------
  logic w_push_drop;
  logic w_pop_empty;

  assign w_push_drop = push_req && w_full;
  assign w_pop_empty = pop_req && !w_avail;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_push_drop) begin
        overflow <= 1'b1;
      end else if (status_clr) begin
        overflow <= 1'b0;
      end
      if (w_pop_empty) begin
        underflow <= 1'b1;
      end else if (status_clr) begin
        underflow <= 1'b0;
      end
    end
  end
`endif

endmodule
`default_nettype wire
